clock_div_prog: RTL and testbench
=================================

CLOCK_DIV_PROG -- requirements
Module: clock_div_prog

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 26, divisor and counter width in bits.
REQ-003 SHALL have parameter DIV_RST, default 50000000, divisor value loaded into every channel at reset (< 2^CNT_W).
REQ-004 SHALL have port CLK_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_n_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port EN_in  input  N_CH  per-channel count enable.
REQ-007 SHALL have port SYNC_in  input  1  restart all channels in phase.
REQ-008 SHALL have port LOAD_in  input  1  single-cycle divisor write strobe.
REQ-009 SHALL have port CH_SEL_in  input  max(1,clog2(N_CH))  channel addressed by LOAD_in.
REQ-010 SHALL have port DIV_in  input  CNT_W  divisor value written by LOAD_in.
REQ-011 SHALL have port LOAD_ACK_out  output  N_CH  per-channel one-cycle pulse: new divisor now active.
REQ-012 SHALL have port TICK_out  output  N_CH  per-channel registered one-cycle strobe every D enabled cycles.
REQ-013 SHALL have port SQ_out  output  N_CH  per-channel registered square wave, period 2*D cycles.

Function
REQ-014 Each channel SHALL hold active divisor D, shadow divisor S, pending flag P, counter C (CNT_W bits).
REQ-015 Effective divisor SHALL be max(D,1); D=0 and D=1 both give a tick on every enabled cycle.
REQ-016 Channel enabled, C == effective D-1: next edge SHALL set C=0 and TICK_out=1 (wrap edge); otherwise C SHALL increment and TICK_out=0.
REQ-017 EN_in low SHALL hold C, force TICK_out to 0 next edge, hold SQ_out.
REQ-018 LOAD_in high with CH_SEL_in < N_CH SHALL write S=DIV_in and set P for that channel; CH_SEL_in >= N_CH SHALL be ignored, no ack.
REQ-019 LOAD to a channel with P already set SHALL overwrite S; one ack only, for the last value.
REQ-020 Enabled channel with P set: D=S, P=0 and LOAD_ACK_out=1 SHALL occur on the wrap edge, same edge as the tick; current period completes with old D.
REQ-021 Disabled channel with P set: next edge SHALL apply D=S, clear P, set C=0, pulse LOAD_ACK_out.
REQ-022 LOAD_in and wrap for the same channel on the same edge: wrap SHALL apply the previous S if pending; new value SHALL become pending.
REQ-023 SYNC_in high SHALL, next edge, set C=0 and SQ_out=0 on all channels, suppress TICK_out, apply all pending S (including a same-cycle LOAD) with LOAD_ACK_out for each applied.
REQ-024 Counter arithmetic SHALL be unsigned CNT_W bits; C never exceeds effective D-1 except after D is lowered, where C SHALL wrap through 2^CNT_W-1 to 0 without a tick; the pending mechanism prevents this in normal use.
REQ-025 All outputs SHALL be driven directly from flops.

Reset
REQ-026 RST_n_in low SHALL immediately force C=0, D=DIV_RST, S=DIV_RST, P=0, TICK_out=0, LOAD_ACK_out=0, SQ_out=0, regardless of clock.
REQ-027 Reset asserted mid-period or with a load pending SHALL discard the pending load without ack.
REQ-028 First tick after reset release SHALL occur on the effective-D-th enabled edge.

Configuration
REQ-029 Macro CLOCK_DIV_PROG_SQUARE_OUT_EN defined: SQ_out[i] SHALL toggle on every wrap edge of channel i (50% duty, period 2*D cycles).
REQ-030 Macro undefined: SQ_out SHALL be constant 0, with no toggle flops synthesised; all other behaviour unchanged.

Verification
REQ-031 Reset release, EN_in all 1, defaults overridden to DIV_RST=5 -> TICK_out all-channel pulse on edges 5,10,15; SQ_out toggles at 5,10 (macro on).
REQ-032 Channel 1 D=4, LOAD DIV_in=7 at cycle 2 of period -> ticks at 4, then 11; LOAD_ACK_out[1] at cycle 4 only.
REQ-033 DIV_in=0 and DIV_in=1 loaded to channel 0 -> TICK_out[0] high every enabled cycle after ack.
REQ-034 Channel 2 disabled, LOAD DIV_in=3 -> ack next edge; enable -> ticks every 3 cycles from C=0.
REQ-035 Channels with D=3,5 running, SYNC_in one cycle -> no tick that edge, both C=0, next ticks 3 and 5 cycles later, SQ_out=0.
REQ-036 RST_n_in low mid-period with load pending -> all outputs 0 at once, no ack, D back to DIV_RST.

Source files
------------

// File: rtl/clock_div_prog.sv
// clock_div_prog: N_CH independent programmable clock-enable dividers.
// Each channel holds an active divisor, a shadow divisor and a pending flag.
// New divisors take effect on a period boundary, on a SYNC pulse, or
// immediately when the channel is idle.
// Optional feature: define CLOCK_DIV_PROG_SQUARE_OUT_EN to build the per-channel
// 50% duty square-wave outputs. Without it SQ_out is tied to zero.
module clock_div_prog #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 26,
  parameter int unsigned DIV_RST = 50000000
) (
  input  logic                                      CLK_in,
  input  logic                                      RST_n_in,
  input  logic [N_CH-1:0]                           EN_in,
  input  logic                                      SYNC_in,
  input  logic                                      LOAD_in,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] CH_SEL_in,
  input  logic [CNT_W-1:0]                          DIV_in,
  output logic [N_CH-1:0]                           LOAD_ACK_out,
  output logic [N_CH-1:0]                           TICK_out,
  output logic [N_CH-1:0]                           SQ_out
);

  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] shd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;
    logic             tick_q;
    logic             ack_q;
    logic             load_hit;
    logic             wrap;
    logic [CNT_W-1:0] last_cnt;

    // Selects that cannot name a real channel never match any index.
    assign load_hit = LOAD_in && (CH_SEL_in == SEL_W'(i));
    // Divisors 0 and 1 both wrap on every enabled cycle.
    assign last_cnt = (div_q == '0) ? '0 : div_q - CNT_W'(1);
    assign wrap     = EN_in[i] && (cnt_q == last_cnt);

    // Counter, divisor shadowing and one-cycle tick/ack strobes.
    always_ff @(posedge CLK_in or negedge RST_n_in) begin
      if (!RST_n_in) begin
        div_q  <= DIV_RST_V;
        shd_q  <= DIV_RST_V;
        cnt_q  <= '0;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        ack_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        ack_q  <= 1'b0;
        if (SYNC_in) begin
          // Restart in phase; a same-cycle write wins over an older pending one.
          cnt_q <= '0;
          if (load_hit) begin
            div_q  <= DIV_in;
            shd_q  <= DIV_in;
            pend_q <= 1'b0;
            ack_q  <= 1'b1;
          end else if (pend_q) begin
            div_q  <= shd_q;
            pend_q <= 1'b0;
            ack_q  <= 1'b1;
          end
        end else begin
          if (EN_in[i]) begin
            if (wrap) begin
              cnt_q  <= '0;
              tick_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          // Pending divisor lands on the period boundary, or at once when idle.
          if (pend_q && (wrap || !EN_in[i])) begin
            div_q  <= shd_q;
            pend_q <= 1'b0;
            ack_q  <= 1'b1;
            if (!EN_in[i]) begin
              cnt_q <= '0;
            end
          end
          // A write on the applying edge queues behind the value just applied.
          if (load_hit) begin
            shd_q  <= DIV_in;
            pend_q <= 1'b1;
          end
        end
      end
    end

    assign TICK_out[i]     = tick_q;
    assign LOAD_ACK_out[i] = ack_q;

`ifdef CLOCK_DIV_PROG_SQUARE_OUT_EN
    logic sq_q;

    // Square wave toggles on each wrap; SYNC restarts it low.
    always_ff @(posedge CLK_in or negedge RST_n_in) begin
      if (!RST_n_in) begin
        sq_q <= 1'b0;
      end else if (SYNC_in) begin
        sq_q <= 1'b0;
      end else if (wrap) begin
        sq_q <= ~sq_q;
      end
    end

    assign SQ_out[i] = sq_q;
`else
    assign SQ_out[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog: directed scenarios plus random
// traffic, compared every cycle against a period-counting reference model.
module tb_clock_div_prog;

  localparam int unsigned N_CH    = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DIV_RST = 5;
  localparam int unsigned SEL_W   = 2;

  logic              CLK_in;
  logic              RST_n_in;
  logic [N_CH-1:0]   EN_in;
  logic              SYNC_in;
  logic              LOAD_in;
  logic [SEL_W-1:0]  CH_SEL_in;
  logic [CNT_W-1:0]  DIV_in;
  logic [N_CH-1:0]   LOAD_ACK_out;
  logic [N_CH-1:0]   TICK_out;
  logic [N_CH-1:0]   SQ_out;

  clock_div_prog #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
    .CLK_in       (CLK_in),
    .RST_n_in     (RST_n_in),
    .EN_in        (EN_in),
    .SYNC_in      (SYNC_in),
    .LOAD_in      (LOAD_in),
    .CH_SEL_in    (CH_SEL_in),
    .DIV_in       (DIV_in),
    .LOAD_ACK_out (LOAD_ACK_out),
    .TICK_out     (TICK_out),
    .SQ_out       (SQ_out)
  );

  initial CLK_in = 1'b0;
  always #5 CLK_in = ~CLK_in;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc      = 0;

  // Reference model: enabled edges since period start, divisor, pending value.
  int              m_div   [N_CH];
  int              m_phase [N_CH];
  int              m_pend  [N_CH];
  logic [N_CH-1:0] m_tick;
  logic [N_CH-1:0] m_ack;
  logic [N_CH-1:0] m_sq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      m_div[ch]   = int'(DIV_RST);
      m_phase[ch] = 0;
      m_pend[ch]  = -1;
    end
    m_tick = '0;
    m_ack  = '0;
    m_sq   = '0;
  endtask

  // Advance the model by one clock edge using the inputs presented now.
  task automatic model_step();
    for (int ch = 0; ch < N_CH; ch++) begin
      bit hit;
      int eff;
      hit = LOAD_in && (int'(CH_SEL_in) == ch);
      m_tick[ch] = 1'b0;
      m_ack[ch]  = 1'b0;
      if (SYNC_in) begin
        m_phase[ch] = 0;
        m_sq[ch]    = 1'b0;
        if (hit) begin
          m_div[ch]  = int'(DIV_in);
          m_pend[ch] = -1;
          m_ack[ch]  = 1'b1;
        end else if (m_pend[ch] >= 0) begin
          m_div[ch]  = m_pend[ch];
          m_pend[ch] = -1;
          m_ack[ch]  = 1'b1;
        end
      end else begin
        if (EN_in[ch]) begin
          eff = (m_div[ch] == 0) ? 1 : m_div[ch];
          m_phase[ch]++;
          if (m_phase[ch] == eff) begin
            m_phase[ch] = 0;
            m_tick[ch]  = 1'b1;
            m_sq[ch]    = ~m_sq[ch];
            if (m_pend[ch] >= 0) begin
              m_div[ch]  = m_pend[ch];
              m_pend[ch] = -1;
              m_ack[ch]  = 1'b1;
            end
          end
        end else if (m_pend[ch] >= 0) begin
          m_div[ch]   = m_pend[ch];
          m_pend[ch]  = -1;
          m_phase[ch] = 0;
          m_ack[ch]   = 1'b1;
        end
        if (hit) m_pend[ch] = int'(DIV_in);
      end
    end
  endtask

  function automatic logic [N_CH-1:0] exp_sq();
`ifdef CLOCK_DIV_PROG_SQUARE_OUT_EN
    return m_sq;
`else
    return '0;
`endif
  endfunction

  // One clock edge: step the model, then sample just after the edge.
  task automatic cycle();
    model_step();
    @(posedge CLK_in);
    #1;
    cyc++;
    check("tick", 32'(TICK_out), 32'(m_tick));
    check("ack", 32'(LOAD_ACK_out), 32'(m_ack));
    check("sq", 32'(SQ_out), 32'(exp_sq()));
  endtask

  task automatic idle_inputs();
    LOAD_in   = 1'b0;
    SYNC_in   = 1'b0;
    CH_SEL_in = '0;
    DIV_in    = '0;
  endtask

  task automatic set_load(input int ch, input int val);
    LOAD_in   = 1'b1;
    CH_SEL_in = SEL_W'(ch);
    DIV_in    = CNT_W'(val);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"}, 32'(TICK_out), 32'(0));
    check({tag, "_ack"}, 32'(LOAD_ACK_out), 32'(0));
    check({tag, "_sq"}, 32'(SQ_out), 32'(0));
  endtask

  initial begin
    logic [N_CH-1:0] all_ch;
    all_ch = '1;
    RST_n_in = 1'b0;
    EN_in    = '0;
    idle_inputs();
    model_reset();

    // Reset state
    repeat (2) @(posedge CLK_in);
    #1;
    check_reset_outputs("reset");
    EN_in    = '1;
    RST_n_in = 1'b1;

    // Default divisor 5: all channels tick on edges 5, 10, 15
    for (int e = 1; e <= 15; e++) begin
      cycle();
      check("first_ticks", 32'(TICK_out), (e % 5 == 0) ? 32'(all_ch) : 32'(0));
`ifdef CLOCK_DIV_PROG_SQUARE_OUT_EN
      check("first_sq", 32'(SQ_out), (((e / 5) % 2) == 1) ? 32'(all_ch) : 32'(0));
`endif
    end

    // Channel 1 at D=4, reload to 7 mid-period: ticks at 4 and 11, ack at 4
    set_load(1, 4);
    SYNC_in = 1'b1;
    cycle();
    check("sync_load_ack", 32'(LOAD_ACK_out[1]), 32'(1));
    idle_inputs();
    for (int e = 1; e <= 12; e++) begin
      if (e == 2) set_load(1, 7);
      cycle();
      idle_inputs();
      check("reload_tick1", 32'(TICK_out[1]), 32'(e == 4 || e == 11));
      check("reload_ack1", 32'(LOAD_ACK_out[1]), 32'(e == 4));
    end

    // Divisors 0 and 1 on channel 0 tick every enabled cycle
    for (int v = 0; v <= 1; v++) begin
      set_load(0, v);
      cycle();
      idle_inputs();
      for (int e = 0; e < 10; e++) begin
        cycle();
        if (e >= 6) check("fast_tick0", 32'(TICK_out[0]), 32'(1));
      end
    end

    // Idle channel 2 applies a load on the next edge, then ticks every 3
    EN_in = 3'b011;
    set_load(2, 3);
    cycle();
    idle_inputs();
    check("idle_noack", 32'(LOAD_ACK_out[2]), 32'(0));
    cycle();
    check("idle_ack", 32'(LOAD_ACK_out[2]), 32'(1));
    EN_in = '1;
    for (int e = 1; e <= 9; e++) begin
      cycle();
      check("idle_tick2", 32'(TICK_out[2]), 32'(e % 3 == 0));
    end

    // SYNC with D=3 and D=5 running: no tick, phases restart together
    set_load(0, 3);
    cycle();
    set_load(1, 5);
    SYNC_in = 1'b1;
    cycle();
    idle_inputs();
    repeat (4) cycle();
    SYNC_in = 1'b1;
    cycle();
    SYNC_in = 1'b0;
    check("sync_tick", 32'(TICK_out), 32'(0));
    check("sync_sq", 32'(SQ_out), 32'(0));
    for (int e = 1; e <= 6; e++) begin
      cycle();
      check("sync_tick0", 32'(TICK_out[0]), 32'(e % 3 == 0));
      check("sync_tick1", 32'(TICK_out[1]), 32'(e == 5));
    end

    // Reset mid-period with a load pending: outputs clear at once, load lost
    repeat (2) cycle();
    set_load(1, 9);
    cycle();
    idle_inputs();
    #2 RST_n_in = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    #2 RST_n_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      check("post_reset_ack", 32'(LOAD_ACK_out), 32'(0));
      check("post_reset_tick", 32'(TICK_out), (e % 5 == 0) ? 32'(all_ch) : 32'(0));
    end

    // Random traffic, including out-of-range selects and async resets
    for (int n = 0; n < 1500; n++) begin
      EN_in     = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '1;
      LOAD_in   = ($urandom_range(0, 3) == 0);
      CH_SEL_in = SEL_W'($urandom_range(0, 3));
      DIV_in    = CNT_W'($urandom_range(0, 9));
      SYNC_in   = ($urandom_range(0, 29) == 0);
      cycle();
      if ($urandom_range(0, 199) == 0) begin
        idle_inputs();
        #2 RST_n_in = 1'b0;
        #1 check_reset_outputs("rand_reset");
        model_reset();
        #2 RST_n_in = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
